ex_alu_stage: RTL and testbench

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/ex_alu_stage_if.sv | 27 ++
 rtl/ex_alu_stage.sv | 141 ++++++++++++++
 tb/tb_ex_alu_stage.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: operation/result handshake bundle for the EX ALU stage
// master: issuer and result consumer (drives operation, flush, out_ready)
// slave : the stage (drives in_ready, out_valid and the registered result)
interface ex_alu_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  rd_in;
    logic        RegWrite_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [4:0]  rd_out;
    logic        RegWrite_out;
    modport master (
        output in_valid, Operation, SrcA, SrcB, rd_in, RegWrite_in, flush, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, rd_out, RegWrite_out
    );
    modport slave (
        input  in_valid, Operation, SrcA, SrcB, rd_in, RegWrite_in, flush, out_ready,
        output in_ready, out_valid, ALUResult, Zero, rd_out, RegWrite_out
    );
endinterface

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: registered EX ALU with valid/ready handshake and an iterative shifter
// clk/reset: clock, synchronous active-low reset; io: operation in, result out, flush
module ex_alu_stage (
    input logic           clk,
    input logic           reset,
    ex_alu_stage_if.slave io
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d, zero_q, zero_d, rw_q, rw_d, sh_rw_q, sh_rw_d;
    logic [31:0] result_q, result_d, sh_val_q, sh_val_d;
    logic [4:0]  rd_q, rd_d, sh_rd_q, sh_rd_d, sh_cnt_q, sh_cnt_d;
    logic [1:0]  sh_op_q, sh_op_d;
    logic [31:0] alu, sra_in, sra_step, shifted;
    logic [4:0]  shamt, step;
    logic        is_shift, free, accept, eq;

    assign shamt    = io.SrcB[4:0];
    assign eq       = io.SrcA == io.SrcB;
    assign is_shift = io.Operation inside {4'b0101, 4'b0111, 4'b0110};
    assign sra_in   = $signed(io.SrcA) >>> shamt;
    assign free     = !out_valid_q || io.out_ready;
    assign accept   = io.in_valid && io.in_ready;
    // each SHIFT cycle moves at most 8 bit positions; low opcode bits pick the shift kind
    assign step     = sh_cnt_q > 5'd8 ? 5'd8 : sh_cnt_q;
    assign sra_step = $signed(sh_val_q) >>> step;
    assign shifted  = sh_op_q == 2'b01 ? sh_val_q << step : sh_op_q == 2'b11 ? sh_val_q >> step : sra_step;

    assign io.in_ready     = reset && state_q == IDLE && !io.flush && free;
    assign io.out_valid    = out_valid_q;
    assign io.ALUResult    = result_q;
    assign io.Zero         = zero_q;
    assign io.rd_out       = rd_q;
    assign io.RegWrite_out = rw_q;

    always_comb begin
        case (io.Operation)
            4'b0000: alu = io.SrcA & io.SrcB;
            4'b0001: alu = io.SrcA | io.SrcB;
            4'b0010: alu = io.SrcA + io.SrcB;
            4'b0011: alu = io.SrcA - io.SrcB;
            4'b0100: alu = io.SrcA ^ io.SrcB;
            4'b0101: alu = io.SrcA << shamt;
            4'b0111: alu = io.SrcA >> shamt;
            4'b0110: alu = sra_in;
            4'b1100: alu = {31'b0, $signed(io.SrcA) < $signed(io.SrcB)};
            4'b1000: alu = {31'b0, eq};
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        sh_val_d    = sh_val_q;
        sh_cnt_d    = sh_cnt_q;
        sh_op_d     = sh_op_q;
        sh_rd_d     = sh_rd_q;
        sh_rw_d     = sh_rw_q;
        if (io.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            sh_cnt_d    = '0;
        end else begin
            if (out_valid_q && io.out_ready) out_valid_d = 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    if (is_shift && shamt != '0) begin
                        state_d  = SHIFT;
                        sh_val_d = io.SrcA;
                        sh_cnt_d = shamt;
                        sh_op_d  = io.Operation[1:0];
                        sh_rd_d  = io.rd_in;
                        sh_rw_d  = io.RegWrite_in;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu;
                        zero_d      = io.Operation == 4'b1000 ? eq : alu == '0;
                        rd_d        = io.rd_in;
                        rw_d        = io.RegWrite_in;
                    end
                end
                SHIFT: begin
                    sh_val_d = shifted;
                    sh_cnt_d = sh_cnt_q - step;
                    if (sh_cnt_q == step) begin
                        state_d = free ? IDLE : HOLD;
                        if (free) begin
                            out_valid_d = 1'b1;
                            result_d    = shifted;
                            zero_d      = shifted == '0;
                            rd_d        = sh_rd_q;
                            rw_d        = sh_rw_q;
                        end
                    end
                end
                HOLD: if (free) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = sh_val_q;
                    zero_d      = sh_val_q == '0;
                    rd_d        = sh_rd_q;
                    rw_d        = sh_rw_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            sh_val_q    <= '0;
            sh_cnt_q    <= '0;
            sh_op_q     <= '0;
            sh_rd_q     <= '0;
            sh_rw_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            sh_val_q    <= sh_val_d;
            sh_cnt_q    <= sh_cnt_d;
            sh_op_q     <= sh_op_d;
            sh_rd_q     <= sh_rd_d;
            sh_rw_q     <= sh_rw_d;
        end
    end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: scoreboard bench for ex_alu_stage with directed and random operations
module tb_ex_alu_stage;
    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    ex_alu_stage_if io();
    ex_alu_stage dut (.clk(clk), .reset(reset), .io(io.slave));

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_pop = 0;
    int   prev_pop = 0;
    bit   rand_ready = 1'b0;
    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6, 4'hC, 4'h8};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input logic rw);
        logic [31:0] r;
        int sh;
        exp_t e;
        sh = int'(b[4:0]);
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h3: r = a - b;
            4'h4: r = a ^ b;
            4'h5: r = a << sh;
            4'h7: r = a >> sh;
            4'h6: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'hC: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            4'h8: r = {31'b0, a == b};
            default: r = 32'h0;
        endcase
        e.res = r;
        e.z   = (op == 4'h8) ? (a == b) : (r == 32'h0);
        e.rd  = rd;
        e.rw  = rw;
        return e;
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        return (op inside {4'h5, 4'h7, 4'h6} && sh != 0) ? (sh + 7) / 8 + 1 : 1;
    endfunction

    // monitor: pops the scoreboard on every consumed result and checks held outputs stay put
    exp_t held;
    bit   hold_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (hold_prev)
            chk("hold_stable", {io.out_valid, io.ALUResult, io.Zero, io.rd_out, io.RegWrite_out}, {1'b1, held});
        hold_prev = reset && !io.flush && io.out_valid && !io.out_ready;
        held = {io.ALUResult, io.Zero, io.rd_out, io.RegWrite_out};
        if (reset && !io.flush && io.out_valid && io.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got ALUResult 0x%0h with no operation outstanding", io.ALUResult);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ALUResult", io.ALUResult, e.res);
                chk("Zero", io.Zero, e.z);
                chk("rd_out", io.rd_out, e.rd);
                chk("RegWrite_out", io.RegWrite_out, e.rw);
                prev_pop = last_pop;
                last_pop = cyc;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) io.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw, output int waited);
        io.in_valid    = 1'b1;
        io.Operation   = op;
        io.SrcA        = a;
        io.SrcB        = b;
        io.rd_in       = rd;
        io.RegWrite_in = rw;
        waited = 0;
        forever begin
            @(negedge clk);
            if (io.in_ready || waited > 200) break;
            waited++;
        end
        if (waited > 200) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
            io.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(model(op, a, b, rd, rw));
            #1;
        end
    endtask

    task automatic measure(input int exp_lat, input string name);
        int n = 0;
        int busy = 0;
        do begin
            @(negedge clk);
            n++;
            if (!io.in_ready) busy++;
        end while (!io.out_valid && n < 50);
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_busy"}, busy, exp_lat - 1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rw, input string name);
        int w;
        issue(op, a, b, rd, rw, w);
        idle();
        measure(latency(op, b), name);
    endtask

    initial begin
        int w1, w2;
        io.in_valid = 1'b0;
        io.flush = 1'b0;
        io.out_ready = 1'b0;
        io.Operation = 4'h0;
        io.SrcA = 32'h0;
        io.SrcB = 32'h0;
        io.rd_in = 5'h0;
        io.RegWrite_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_ALUResult", io.ALUResult, 0);
        chk("rst_Zero", io.Zero, 0);
        chk("rst_rd_out", io.rd_out, 0);
        chk("rst_RegWrite_out", io.RegWrite_out, 0);
        chk("rst_in_ready", io.in_ready, 0);
        sync();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", io.in_ready, 1);
        io.out_ready = 1'b1;
        sync();

        run_op(4'h2, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, "add_ovf");
        chk("add_ovf_result", io.ALUResult, 32'h8000_0000);
        chk("add_ovf_zero", io.Zero, 0);
        chk("add_ovf_rd", io.rd_out, 5);
        sync();

        issue(4'h8, 32'h1234, 32'h1234, 5'd1, 1'b1, w1);
        issue(4'h3, 32'h3, 32'h3, 5'd2, 1'b1, w2);
        idle();
        chk("b2b_wait_eq", w1, 0);
        chk("b2b_wait_sub", w2, 0);
        repeat (2) @(negedge clk);
        chk("b2b_gap", last_pop - prev_pop, 1);
        sync();

        run_op(4'h6, 32'h8000_0000, 32'd31, 5'd3, 1'b1, "sra31");
        chk("sra31_result", io.ALUResult, 32'hFFFF_FFFF);
        sync();
        run_op(4'h7, 32'h8000_0000, 32'd31, 5'd4, 1'b0, "srl31");
        chk("srl31_result", io.ALUResult, 32'h1);
        sync();

        issue(4'h0, 32'hF0F0_1234, 32'hFF00_FF00, 5'd6, 1'b1, w1);
        idle();
        io.out_ready = 1'b0;
        fork
            begin
                issue(4'h5, 32'h1, 32'd9, 5'd8, 1'b1, w2);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 io.out_ready = 1'b1;
            end
        join
        chk("sll9_wait", w2, 3);
        measure(3, "sll9");
        chk("sll9_result", io.ALUResult, 32'h200);
        sync();

        issue(4'h5, 32'h1, 32'd20, 5'd9, 1'b1, w1);
        idle();
        sync();
        io.flush = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_in_ready", io.in_ready, 0);
        sync();
        io.flush = 1'b0;
        @(negedge clk);
        chk("post_flush_in_ready", io.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("post_flush_out_valid", io.out_valid, 0);
            @(negedge clk);
        end
        sync();

        run_op(4'h8, 32'h5, 32'h5, 5'd7, 1'b1, "eq_pre_rst");
        sync();
        issue(4'h5, 32'h3, 32'd31, 5'd9, 1'b1, w1);
        idle();
        sync();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midshift_rst_in_ready", io.in_ready, 0);
        sync();
        reset = 1'b1;
        @(negedge clk);
        chk("midshift_rst_out_valid", io.out_valid, 0);
        chk("midshift_rst_ALUResult", io.ALUResult, 0);
        chk("midshift_rst_Zero", io.Zero, 0);
        chk("midshift_rst_rd_out", io.rd_out, 0);
        chk("midshift_rst_RegWrite_out", io.RegWrite_out, 0);
        sync();
        run_op(4'h1, 32'hF0, 32'h0F, 5'd3, 1'b1, "or_after_rst");
        chk("or_after_rst_result", io.ALUResult, 32'hFF);
        sync();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            int w;
            op = ($urandom_range(0, 15) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            issue(op, a, b, 5'($urandom), 1'($urandom), w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 24) == 0) begin
                idle();
                io.flush = 1'b1;
                sb.delete();
                sync();
                io.flush = 1'b0;
            end
        end
        idle();
        rand_ready = 1'b0;
        io.out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
